rom_loader: RTL and testbench

//  Instruction memory placed upstream of the Hack CPU. Drives `instruction` from rom[pc] and

---
 rtl/rom_loader.sv | 160 ++++++++++++++++
 tb/tb_rom_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Hack CPU instruction ROM with a byte-streamed program loader; holds the CPU in reset while loading.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing 16-bit checksum on every frame.
module rom_loader #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic [15:0] instruction,
    output logic        cpu_reset,
    input  logic        load_start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        load_busy,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO, RUN, ERR
    } stateT;

    stateT             state, stateNext;
    logic [15:0]       rom [DEPTH];
    logic [7:0]        hiByte;
    logic [15:0]       lenWords;
    logic [ADDR_W-1:0] wrAddr;
    logic [15:0]       rxWord;
    logic              xfer, romWe, lenTooBig, lastWord;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0]       chkSum;
`endif

    assign xfer        = byte_valid & byte_ready;
    assign rxWord      = {hiByte, byte_data};
    assign lenTooBig   = 32'(rxWord) > DEPTH;
    assign lastWord    = (words_loaded + 16'd1) == lenWords;
    assign instruction = rom[pc[ADDR_W-1:0]];

    generate
        if (ADDR_W < 16) begin : gPcHi
            logic unusedPcHi;
            assign unusedPcHi = ^pc[15:ADDR_W];
        end
    endgenerate

    always_comb begin
        byte_ready = 1'b0;
        load_busy  = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DAT_HI, DAT_LO: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CHK_HI, CHK_LO: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        stateNext = state;
        romWe     = 1'b0;
        if (load_start) begin
            stateNext = LEN_HI;
        end else begin
            case (state)
                LEN_HI: if (xfer) stateNext = LEN_LO;
                LEN_LO: if (xfer) begin
                    if (lenTooBig)
                        stateNext = ERR;
                    else if (rxWord == 16'd0)
`ifdef ROM_LOADER_CHECKSUM_EN
                        stateNext = CHK_HI;
`else
                        stateNext = RUN;
`endif
                    else
                        stateNext = DAT_HI;
                end
                DAT_HI: if (xfer) stateNext = DAT_LO;
                DAT_LO: if (xfer) begin
                    romWe = 1'b1;
                    if (lastWord)
`ifdef ROM_LOADER_CHECKSUM_EN
                        stateNext = CHK_HI;
`else
                        stateNext = RUN;
`endif
                    else
                        stateNext = DAT_HI;
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                CHK_HI: if (xfer) stateNext = CHK_LO;
                CHK_LO: if (xfer) stateNext = (rxWord == chkSum) ? RUN : ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cpu_reset    <= 1'b1;
            load_err     <= 1'b0;
            words_loaded <= '0;
            wrAddr       <= '0;
            hiByte       <= '0;
            lenWords     <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            chkSum       <= '0;
`endif
        end else begin
            state <= stateNext;
            // Released only once RUN has been held for a full cycle; asserted as soon as RUN is left.
            cpu_reset <= !(state == RUN && stateNext == RUN);
            if (load_start) begin
                wrAddr       <= '0;
                words_loaded <= '0;
                load_err     <= 1'b0;
            end else if (xfer) begin
                case (state)
                    LEN_HI, DAT_HI, CHK_HI: hiByte <= byte_data;
                    LEN_LO: begin
                        lenWords <= rxWord;
                        if (lenTooBig) load_err <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                        chkSum <= rxWord;
`endif
                    end
                    DAT_LO: begin
                        wrAddr       <= wrAddr + 1'b1;
                        words_loaded <= words_loaded + 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                        chkSum <= chkSum + rxWord;
`endif
                    end
`ifdef ROM_LOADER_CHECKSUM_EN
                    CHK_LO: if (rxWord != chkSum) load_err <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end

    // ROM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (romWe) rom[wrAddr] <= rxWord;
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader (ADDR_W=4); follows ROM_LOADER_CHECKSUM_EN if defined.
module tb_rom_loader;

    typedef logic [15:0] wordQT[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = '0;
    logic [15:0] instruction;
    logic        cpu_reset;
    logic        load_start = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        load_busy;
    logic        load_err;
    logic [15:0] words_loaded;

    int unsigned total = 0;
    int unsigned bad = 0;

    rom_loader #(.ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
        .cpu_reset(cpu_reset), .load_start(load_start), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .load_busy(load_busy),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int unsigned gap);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && !byte_ready; i++) @(negedge clk);
        check("ready", 16'(byte_ready), 16'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic sendBody(input wordQT w, input int unsigned gap);
        logic [15:0] n;
`ifdef ROM_LOADER_CHECKSUM_EN
        logic [15:0] sum;
`endif
        n = 16'(w.size());
`ifdef ROM_LOADER_CHECKSUM_EN
        sum = n;
`endif
        sendByte(n[15:8], gap);
        sendByte(n[7:0], gap);
        foreach (w[i]) begin
            sendByte(w[i][15:8], gap);
            sendByte(w[i][7:0], gap);
`ifdef ROM_LOADER_CHECKSUM_EN
            sum = sum + w[i];
`endif
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        sendByte(sum[15:8], gap);
        sendByte(sum[7:0], gap);
`endif
    endtask

    task automatic readRom(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        pc = addr;
        #1;
        check(tag, instruction, exp);
    endtask

    task automatic checkReleased(input string tag);
        check({tag, "_rst_hold"}, 16'(cpu_reset), 16'd1);
        @(negedge clk);
        check({tag, "_rst_rel"}, 16'(cpu_reset), 16'd0);
        check({tag, "_busy"}, 16'(load_busy), 16'd0);
        check({tag, "_err"}, 16'(load_err), 16'd0);
    endtask

    initial begin
        wordQT w16;

        // reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_reset", 16'(cpu_reset), 16'd1);
        check("rst_ready", 16'(byte_ready), 16'd0);
        check("rst_busy", 16'(load_busy), 16'd0);
        check("rst_err", 16'(load_err), 16'd0);
        check("rst_words", words_loaded, 16'd0);

        // basic N=2 load
        pulseStart();
        check("t2_busy", 16'(load_busy), 16'd1);
        sendBody('{16'h012C, 16'hEC10}, 0);
        check("t2_words", words_loaded, 16'd2);
        checkReleased("t2");
        readRom("t2_rom0", 16'h0000, 16'h012C);
        readRom("t2_rom1", 16'h0001, 16'hEC10);
        readRom("t2_pc_hi_ignored", 16'hFFF1, 16'hEC10);

        // stalled bytes, new contents; cpu_reset must rise on leaving RUN
        pulseStart();
        check("t3_rst_rise", 16'(cpu_reset), 16'd1);
        sendBody('{16'h1234, 16'hABCD}, 2);
        checkReleased("t3");
        readRom("t3_rom0", 16'h0000, 16'h1234);
        readRom("t3_rom1", 16'h0001, 16'hABCD);

        // restart mid-frame; byte presented with load_start is dropped
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h02, 1);
        sendByte(8'h77, 0);
        byte_data  = 8'h88;
        byte_valid = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b0;
        check("t4_busy", 16'(load_busy), 16'd1);
        check("t4_words_clr", words_loaded, 16'd0);
        sendBody('{16'h0005}, 0);
        check("t4_words", words_loaded, 16'd1);
        checkReleased("t4");
        readRom("t4_rom0", 16'h0000, 16'h0005);
        readRom("t4_rom1_kept", 16'h0001, 16'hABCD);

        // N=17 exceeds depth 16
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h11, 0);
        @(negedge clk);
        check("t5_err", 16'(load_err), 16'd1);
        check("t5_cpu_reset", 16'(cpu_reset), 16'd1);
        check("t5_ready", 16'(byte_ready), 16'd0);
        check("t5_busy", 16'(load_busy), 16'd0);
        check("t5_words", words_loaded, 16'd0);
        readRom("t5_rom0", 16'h0000, 16'h0005);

        // N=16 fills the ROM exactly; load_start clears load_err
        pulseStart();
        check("t6_err_clr", 16'(load_err), 16'd0);
        for (int i = 0; i < 16; i++) w16.push_back(16'h1000 + 16'(i));
        sendBody(w16, 0);
        check("t6_words", words_loaded, 16'd16);
        checkReleased("t6");
        readRom("t6_rom0", 16'h0000, 16'h1000);
        readRom("t6_rom15", 16'h000F, 16'h100F);

        // N=0 keeps the previous program
        pulseStart();
        sendBody('{}, 0);
        check("t7_words", words_loaded, 16'd0);
        checkReleased("t7");
        readRom("t7_rom0", 16'h0000, 16'h1000);

        // reset in the middle of a load
        pulseStart();
        sendBody('{16'hAAAA}, 0);
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'hBB, 0);
        sendByte(8'hBB, 0);
        sendByte(8'hCC, 0);
        #2 reset = 1'b1;
        #1;
        check("t8_busy_async", 16'(load_busy), 16'd0);
        check("t8_cpu_reset", 16'(cpu_reset), 16'd1);
        check("t8_words", words_loaded, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        readRom("t8_rom0_partial", 16'h0000, 16'hBBBB);
        check("t8_ready", 16'(byte_ready), 16'd0);

`ifdef ROM_LOADER_CHECKSUM_EN
        // bad checksum keeps CPU in reset
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'h01, 0);
        sendByte(8'h2C, 0);
        sendByte(8'hEC, 0);
        sendByte(8'h10, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        repeat (2) @(negedge clk);
        check("t9_err", 16'(load_err), 16'd1);
        check("t9_cpu_reset", 16'(cpu_reset), 16'd1);
        check("t9_busy", 16'(load_busy), 16'd0);
        readRom("t9_rom0", 16'h0000, 16'h012C);
        // correct checksum 0xED3E releases
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'h01, 0);
        sendByte(8'h2C, 0);
        sendByte(8'hEC, 0);
        sendByte(8'h10, 0);
        sendByte(8'hED, 0);
        sendByte(8'h3E, 0);
        checkReleased("t9ok");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
